// File: rtl/rtf_video_fifo_wc_if.sv
// rtl/rtf_video_fifo_wc_if.sv - write/read/status bundle for the width-converting video FIFO
interface rtf_video_fifo_wc_if #(
    parameter int WID_IN     = 128,
    parameter int WID_OUT    = 32,
    parameter int DEPTH_LOG2 = 7,
    parameter int CW         = DEPTH_LOG2 + $clog2(WID_IN / WID_OUT) + 1
);
    logic               i_clr;
    logic               i_wr;
    logic [WID_IN-1:0]  i_di;
    logic               i_rd;
    logic [WID_OUT-1:0] o_do;
    logic               o_dv;
    logic [CW-1:0]      o_cnt;
    logic               o_full;
    logic               o_empty;
    logic [CW-1:0]      i_lowat;
    logic               o_req;
    logic               o_ovf;
    logic               o_unf;

    modport master (
        output i_clr, i_wr, i_di, i_rd, i_lowat,
        input  o_do, o_dv, o_cnt, o_full, o_empty, o_req, o_ovf, o_unf
    );

    modport slave (
        input  i_clr, i_wr, i_di, i_rd, i_lowat,
        output o_do, o_dv, o_cnt, o_full, o_empty, o_req, o_ovf, o_unf
    );
endinterface

// File: rtl/rtf_video_fifo_wc.sv
// rtl/rtf_video_fifo_wc.sv - wide-in, narrow-out video pixel FIFO with flags and fetch request
module rtf_video_fifo_wc #(
    parameter int WID_IN     = 128,
    parameter int WID_OUT    = 32,
    parameter int DEPTH_LOG2 = 7,
    parameter int CW         = DEPTH_LOG2 + $clog2(WID_IN / WID_OUT) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rtf_video_fifo_wc_if.slave    bus
);
    localparam int RATIO = WID_IN / WID_OUT;
    localparam int RLOG  = $clog2(RATIO);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [WID_IN-1:0]  r_mem [DEPTH];
    logic [PW-1:0]      r_wp;
    logic [CW-1:0]      r_rp;
    logic [WID_OUT-1:0] r_do;
    logic               r_dv;
    logic               r_ovf;
    logic               r_unf;

    logic [CW-1:0]      w_cnt;
    logic [PW-1:0]      w_rword;
    logic [CW-1:0]      w_sub;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [WID_IN-1:0]  w_rdata;
    logic [WID_OUT-1:0] w_subdata;

    // A write word keeps its slot until its last subword has been read.
    assign w_cnt     = (CW'(r_wp) << RLOG) - r_rp;
    assign w_rword   = r_rp[CW-1:RLOG];
    assign w_sub     = r_rp & CW'(RATIO - 1);
    assign w_full    = (r_wp - w_rword) == PW'(DEPTH);
    assign w_empty   = (w_cnt == '0);
    assign w_wr_acc  = bus.i_wr && !w_full && !bus.i_clr;
    assign w_rd_acc  = bus.i_rd && !w_empty && !bus.i_clr;
    assign w_rdata   = r_mem[w_rword[DEPTH_LOG2-1:0]];
    assign w_subdata = WID_OUT'(w_rdata >> (w_sub * CW'(WID_OUT)));

    always_ff @(posedge i_clk) begin
        if (w_wr_acc && !i_rst) begin
            r_mem[r_wp[DEPTH_LOG2-1:0]] <= bus.i_di;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_do  <= '0;
            r_dv  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (bus.i_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_do  <= '0;
            r_dv  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wp <= r_wp + 1'b1;
            end
            if (bus.i_wr && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_rd_acc) begin
                r_do <= w_subdata;
                r_dv <= 1'b1;
                r_rp <= r_rp + 1'b1;
            end else begin
                r_dv <= 1'b0;
            end
            if (bus.i_rd && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign bus.o_do    = r_do;
    assign bus.o_dv    = r_dv;
    assign bus.o_cnt   = w_cnt;
    assign bus.o_full  = w_full;
    assign bus.o_empty = w_empty;
    assign bus.o_req   = !w_full && (w_cnt < bus.i_lowat);
    assign bus.o_ovf   = r_ovf;
    assign bus.o_unf   = r_unf;
endmodule

// File: tb/tb_rtf_video_fifo_wc.sv
// tb/tb_rtf_video_fifo_wc.sv - scoreboard bench for the width-converting video FIFO
module tb_rtf_video_fifo_wc;
    localparam int WID_IN     = 128;
    localparam int WID_OUT    = 32;
    localparam int DEPTH_LOG2 = 7;
    localparam int CW         = 10;
    localparam int RATIO      = 4;
    localparam int DEPTH      = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rtf_video_fifo_wc_if #(
        .WID_IN(WID_IN), .WID_OUT(WID_OUT), .DEPTH_LOG2(DEPTH_LOG2), .CW(CW)
    ) bus ();

    rtf_video_fifo_wc #(
        .WID_IN(WID_IN), .WID_OUT(WID_OUT), .DEPTH_LOG2(DEPTH_LOG2), .CW(CW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [WID_OUT-1:0] m_q[$];
    logic [WID_OUT-1:0] m_do;
    logic               m_dv;
    logic               m_ovf;
    logic               m_unf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_full();
        return ((m_q.size() + RATIO - 1) / RATIO) == DEPTH;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_do  = '0;
        m_dv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_all();
        check("dv",    64'(bus.o_dv),    64'(m_dv));
        check("do",    64'(bus.o_do),    64'(m_do));
        check("cnt",   64'(bus.o_cnt),   64'(m_q.size()));
        check("full",  64'(bus.o_full),  64'(m_full()));
        check("empty", 64'(bus.o_empty), 64'(m_q.size() == 0));
        check("req",   64'(bus.o_req),   64'(!m_full() && (m_q.size() < int'(bus.i_lowat))));
        check("ovf",   64'(bus.o_ovf),   64'(m_ovf));
        check("unf",   64'(bus.o_unf),   64'(m_unf));
    endtask

    task automatic step(input bit w, input logic [WID_IN-1:0] d, input bit r, input bit c);
        bit full_pre;
        bit empty_pre;
        bus.i_wr  = w;
        bus.i_di  = d;
        bus.i_rd  = r;
        bus.i_clr = c;
        full_pre  = m_full();
        empty_pre = (m_q.size() == 0);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (r && !empty_pre) begin
                m_do = m_q.pop_front();
                m_dv = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (r && empty_pre) m_unf = 1'b1;
            if (w && !full_pre) begin
                for (int k = 0; k < RATIO; k++) m_q.push_back(d[k*WID_OUT +: WID_OUT]);
            end
            if (w && full_pre) m_ovf = 1'b1;
        end
        #1;
        check_all();
    endtask

    function automatic logic [WID_IN-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [WID_IN-1:0] pat;
        bus.i_clr   = 1'b0;
        bus.i_wr    = 1'b0;
        bus.i_di    = '0;
        bus.i_rd    = 1'b0;
        bus.i_lowat = CW'(64);
        model_reset();
        #1;
        check_all();
        check("rst_req", 64'(bus.o_req), 64'd1);
        check("rst_empty", 64'(bus.o_empty), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        step(0, '0, 0, 0);

        pat = 128'h0000_0003_0000_0002_0000_0001_0000_0000;
        pat = {32'h3, 32'h2, 32'h1, 32'h0};
        step(1, pat, 0, 0);
        check("one_cnt", 64'(bus.o_cnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 1, 0);
            check("sub_do", 64'(bus.o_do), 64'(i));
            check("sub_cnt", 64'(bus.o_cnt), 64'(3 - i));
        end
        step(0, '0, 0, 0);

        for (int i = 0; i < DEPTH; i++) step(1, rnd_word(), 0, 0);
        check("fill_full", 64'(bus.o_full), 64'd1);
        check("fill_cnt", 64'(bus.o_cnt), 64'd512);
        check("fill_req", 64'(bus.o_req), 64'd0);
        step(1, rnd_word(), 0, 0);
        check("ovf_set", 64'(bus.o_ovf), 64'd1);
        check("ovf_cnt", 64'(bus.o_cnt), 64'd512);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        check("full_hold", 64'(bus.o_full), 64'd1);
        step(0, '0, 1, 0);
        check("full_clear", 64'(bus.o_full), 64'd0);
        while (m_q.size() > 0) step(0, '0, 1, 0);

        step(1, rnd_word(), 1, 0);
        check("unf_set", 64'(bus.o_unf), 64'd1);
        check("unf_dv", 64'(bus.o_dv), 64'd0);
        check("unf_cnt", 64'(bus.o_cnt), 64'd4);
        step(0, '0, 1, 0);

        step(0, '0, 0, 1);
        step(1, rnd_word(), 0, 0);
        step(1, rnd_word(), 0, 0);
        for (int i = 0; i < 4000; i++) step((i % 4) == 0, rnd_word(), 1, 0);
        check("stream_ovf", 64'(bus.o_ovf), 64'd0);
        check("stream_unf", 64'(bus.o_unf), 64'd0);

        step(1, rnd_word(), 1, 0);
        step(1, rnd_word(), 1, 1);
        check("clr_cnt", 64'(bus.o_cnt), 64'd0);
        check("clr_empty", 64'(bus.o_empty), 64'd1);
        check("clr_dv", 64'(bus.o_dv), 64'd0);
        step(0, '0, 0, 0);

        bus.i_lowat = CW'(0);
        for (int i = 0; i < 5; i++) step(1, rnd_word(), i[0], 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("arst_cnt", 64'(bus.o_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_lowat = CW'(64);
        step(1, rnd_word(), 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/rtf_video_fifo_wc.md
# rtf_video_fifo_wc

Single-clock, parametrised width-converting video FIFO. It accepts wide memory-fetch words from the bitmap DMA and returns narrow pixel words to the display shifter. It adds full/empty flags, sticky overflow/underflow flags, a low-water fetch request and a synchronous frame flush. It replaces the fixed 128-to-32, 128-deep pixel FIFO in the bitmap controller datapath.

## Interface
- WID_IN, 128, write word width in bits; must equal WID_OUT × RATIO, with RATIO a power of two ≥ 1.
- WID_OUT, 32, read word width in bits.
- DEPTH_LOG2, 7, log2 of storage depth in write words (DEPTH = 128).
- CW, DEPTH_LOG2 + log2(RATIO) + 1, width of the count and threshold fields, in read words.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush, pulsed at vertical sync.
- wr  in  1  write strobe.
- di  in  WID_IN  write data.
- rd  in  1  read strobe.
- do  out  WID_OUT  registered read data.
- dv  out  1  do valid; high one cycle after an accepted read.
- cnt  out  CW  occupancy in read words.
- full  out  1  no free write-word slot.
- empty  out  1  cnt == 0.
- lowat  in  CW  low-water threshold, in read words.
- req  out  1  fetch request.
- ovf  out  1  sticky overflow: a write arrived while full.
- unf  out  1  sticky underflow: a read arrived while empty.

## Operation
- Storage: DEPTH × WID_IN RAM.
- Write pointer wp is DEPTH_LOG2+1 bits and counts write words.
- Read pointer rp is CW bits and counts read words. rp[CW-1:log2 RATIO] is the write-word index; the low bits select the subword.
- Subword order: subword 0 is di[WID_OUT-1:0], then ascending.
- cnt = ({wp, log2(RATIO) zeros} − rp), mod 2^CW. Range 0 to DEPTH×RATIO.
- full = (wp − rp[CW-1:log2 RATIO]) == DEPTH, mod 2^(DEPTH_LOG2+1). A write word occupies its slot until its last subword is read.
- empty = (cnt == 0).
- Accepted write: wr && !full && !clr. Stores di at wp[DEPTH_LOG2-1:0], then wp+1.
- Dropped write: wr && full. Data is discarded and ovf is set.
- Accepted read: rd && !empty && !clr. do <= selected subword, dv <= 1, rp+1.
- Rejected read: rd && empty. do holds, dv <= 0, unf is set.
- No read in a cycle: dv <= 0 and do holds its value.
- req = !full && (cnt < lowat), combinational. lowat = 0 holds req low.
- ovf and unf stay set until clr or rst.
- Flags, req and cnt are computed from state before the current edge. In a simultaneous read and write:
  - When full, the write is still dropped.
  - When empty, the read still underflows and the write is accepted.
- clr has priority over wr and rd. It sets wp and rp to 0, clears ovf, unf and dv, and sets do to 0. RAM contents are don't-care.
- Pointer wrap is modular. There is no special case at DEPTH boundaries.

## Timing
- Reset values: do = 0, dv = 0, cnt = 0, full = 0, empty = 1, req = (lowat ≠ 0), ovf = 0, unf = 0, wp = rp = 0.
- Reset assertion takes effect immediately. State is also held during any reset asserted mid-stream; no partial write survives.
- Write-to-read latency: a word written at edge N is readable (empty = 0) for a rd sampled at edge N+1. Its data appears on do after edge N+1.
- Read latency: do and dv are valid one cycle after the rd edge. Back-to-back reads give one word per clock.
- cnt, full, empty and req update in the cycle after the causing edge. All four are combinational from registered pointers.
- With RATIO = 1, full asserts at cnt = DEPTH. With RATIO > 1, full deasserts on the edge that reads subword RATIO−1 of the oldest word.
- Throughput: write one word per clock while not full, and read one word per clock while not empty.

## Test plan
- Reset then idle, with lowat = 64: outputs at reset values, req = 1, empty = 1.
- Write 0x..0003_0002_0001_0000 once, then four reads: do = 0, 1, 2, 3 on successive cycles with dv high. cnt goes 4, 3, 2, 1, 0 and empty returns to 1.
- Fill 128 writes with no reads: full = 1 after the 128th, cnt = 512, req = 0. A 129th write sets ovf and cnt stays 512. Three reads keep full = 1; the 4th read clears it.
- Read on empty together with a write: unf = 1 and dv = 0. The next cycle has cnt = 4; the next read returns subword 0.
- Stream 1000 writes and reads at 1:4 rates across pointer wrap: data order is preserved and ovf = unf = 0.
- Pulse clr mid-stream together with wr and rd: next cycle cnt = 0, empty = 1, ovf = unf = 0, dv = 0, and the write is not stored.
